// File: rtl/dram_port_arbiter.sv
// ---------------------------------------------------------------------------
// dram_port_arbiter
//
// Round-robin arbiter that lets NUM_CORES load/store requesters share one port
// of the dual-port DRAM. Only one request is in flight at a time. Each access
// takes three cycles: IDLE (grant), ACCESS (DRAM samples the port), and RESP
// (read data comes back). The requester then gets a one-cycle ack pulse. One
// instance of this block sits in front of each DRAM port.
//
// Ports
//   clk        in   1                  clock, all state changes on posedge
//   rst        in   1                  asynchronous active-high reset
//   req        in   NUM_CORES          per-core request, held until ack
//   we         in   NUM_CORES          per-core 1=write 0=read
//   addr       in   NUM_CORES*ADDR_W   core i address at [i*ADDR_W +: ADDR_W]
//   wdata      in   NUM_CORES*DATA_W   core i write data at [i*DATA_W +: DATA_W]
//   ack        out  NUM_CORES          one-cycle completion pulse per core
//   rdata      out  DATA_W             last read result, valid from ack cycle
//   busy       out  1                  high while an access is in flight
//   mem_we     out  1                  DRAM write_en
//   mem_addr   out  ADDR_W             DRAM addr
//   mem_wdata  out  DATA_W             DRAM data_in
//   mem_rdata  in   DATA_W             DRAM data_out (one-cycle registered)
// ---------------------------------------------------------------------------
module dram_port_arbiter #(
  parameter int NUM_CORES = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES-1:0]        we,
  input  logic [NUM_CORES*ADDR_W-1:0] addr,
  input  logic [NUM_CORES*DATA_W-1:0] wdata,
  output logic [NUM_CORES-1:0]        ack,
  output logic [DATA_W-1:0]           rdata,
  output logic                        busy,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [NUM_CORES-1:0] ONE_HOT0 = NUM_CORES'(1);

  logic [1:0]           state;
  logic [IDX_W-1:0]     rr;
  logic [IDX_W-1:0]     idx;
  logic                 lat_we;

  logic [NUM_CORES-1:0] eligible;
  logic                 grant_valid;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     next_rr;

  logic [ADDR_W-1:0]    addr_arr  [NUM_CORES];
  logic [DATA_W-1:0]    wdata_arr [NUM_CORES];

  // Split the flat per-core buses into arrays. This lets the granted core be
  // selected with a plain index.
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_unpack
    assign addr_arr[i]  = addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = wdata[i*DATA_W +: DATA_W];
  end

  // A core whose ack is high this cycle is still holding its old request.
  // It is masked so the completed request is not granted a second time.
  assign eligible = req & ~ack;

  // Round-robin pick. Scan upward from the rr pointer and take the first
  // eligible core. The pointer then moves one past the winner.
  always_comb begin
    int               pos;
    logic [IDX_W-1:0] cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    next_rr     = '0;
    pos         = 0;
    cand        = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      pos  = (int'(rr) + k) % NUM_CORES;
      cand = IDX_W'(pos);
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
        next_rr     = IDX_W'((pos + 1) % NUM_CORES);
      end
    end
  end

  // Main access sequencer. All outputs are registered here.
  // The DRAM port registers (mem_*) double as the latched copy of the granted
  // request, so later changes on the core inputs cannot disturb an access.
  // mem_we is raised only on entry to ACCESS and dropped on leaving it, so
  // the DRAM sees at most one write edge per granted write. Reset clears it
  // asynchronously, which aborts a write before its edge arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr        <= '0;
      idx       <= '0;
      lat_we    <= 1'b0;
      ack       <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            idx       <= grant_idx;
            lat_we    <= we[grant_idx];
            mem_we    <= we[grant_idx];
            mem_addr  <= addr_arr[grant_idx];
            mem_wdata <= wdata_arr[grant_idx];
            rr        <= next_rr;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_we <= 1'b0;
          state  <= RESP;
        end
        RESP: begin
          if (!lat_we) begin
            rdata <= mem_rdata;
          end
          ack   <= ONE_HOT0 << idx;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mem_we <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dram_port_arbiter
//
// Directed bench for dram_port_arbiter with NUM_CORES=2. A small registered
// DRAM model is attached to the port. Most traffic comes from a cycle-by-cycle
// vector table. Each row gives the inputs applied before an edge and the
// outputs expected just after it. The async-reset corner cases are
// hand-written sequences.
// ---------------------------------------------------------------------------
module tb_dram_port_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  ack;
  logic [15:0] rdata;
  logic        busy;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] dram [0:255];

  int errors;
  int checks;

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  e_ack;
    logic        e_busy;
    logic        e_mem_we;
    logic [15:0] e_mem_addr;
    logic [15:0] e_mem_wdata;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  dram_port_arbiter #(
    .NUM_CORES(2),
    .ADDR_W   (16),
    .DATA_W   (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .ack      (ack),
    .rdata    (rdata),
    .busy     (busy),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DRAM port model: the write and the registered read both happen at posedge
  always @(posedge clk) begin
    if (mem_we) dram[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= dram[mem_addr[7:0]];
  end

  task automatic checkOutput(input string name, input int row,
                             input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s (step %0d): got %h, expected %h", name, row, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst   = v.rst;
    req   = v.req;
    we    = v.we;
    addr  = {v.a1, v.a0};
    wdata = {v.d1, v.d0};
  endtask

  task automatic checkVector(input int row, input vec_t v);
    checkOutput("ack",       row, {14'd0, ack},    {14'd0, v.e_ack});
    checkOutput("busy",      row, {15'd0, busy},   {15'd0, v.e_busy});
    checkOutput("mem_we",    row, {15'd0, mem_we}, {15'd0, v.e_mem_we});
    checkOutput("mem_addr",  row, mem_addr,        v.e_mem_addr);
    checkOutput("mem_wdata", row, mem_wdata,       v.e_mem_wdata);
    checkOutput("rdata",     row, rdata,           v.e_rdata);
  endtask

  task automatic addVec(input logic r, input logic [1:0] rq, input logic [1:0] w,
                        input logic [15:0] a0, input logic [15:0] a1,
                        input logic [15:0] d0, input logic [15:0] d1,
                        input logic [1:0] e_ack, input logic e_busy, input logic e_mwe,
                        input logic [15:0] e_maddr, input logic [15:0] e_mwdata,
                        input logic [15:0] e_rdata);
    vec_t v;
    v.rst = r;  v.req = rq; v.we = w;
    v.a0 = a0;  v.a1 = a1;  v.d0 = d0; v.d1 = d1;
    v.e_ack = e_ack; v.e_busy = e_busy; v.e_mem_we = e_mwe;
    v.e_mem_addr = e_maddr; v.e_mem_wdata = e_mwdata; v.e_rdata = e_rdata;
    vecs.push_back(v);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 256; i++) dram[i] = 16'h0000;
    dram[1] = 16'h00AA;
    dram[2] = 16'h00BB;
    dram[3] = 16'h1234;
    dram[5] = 16'h5A5A;

    // Vector table:  rst req we  a0       a1       d0       d1     | ack busy mwe maddr   mwdata   rdata
    // Core0 writes 0x10=0x55, then reads it back (ack two edges after grant)
    addVec(0, 2'b01, 2'b01, 16'h0010, 16'h0000, 16'h0055, 16'h0000, 2'b00, 1, 1, 16'h0010, 16'h0055, 16'h0000);
    addVec(0, 2'b01, 2'b01, 16'h0010, 16'h0000, 16'h0055, 16'h0000, 2'b00, 1, 0, 16'h0010, 16'h0055, 16'h0000);
    addVec(0, 2'b01, 2'b01, 16'h0010, 16'h0000, 16'h0055, 16'h0000, 2'b01, 0, 0, 16'h0010, 16'h0055, 16'h0000);
    addVec(0, 2'b01, 2'b00, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0010, 16'h0055, 16'h0000);
    addVec(0, 2'b01, 2'b00, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1, 0, 16'h0010, 16'h0000, 16'h0000);
    addVec(0, 2'b01, 2'b00, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1, 0, 16'h0010, 16'h0000, 16'h0000);
    addVec(0, 2'b01, 2'b00, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 2'b01, 0, 0, 16'h0010, 16'h0000, 16'h0055);
    addVec(0, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0010, 16'h0000, 16'h0055);
    // Reset, then both cores read in the same cycle: core0 first, core1 three cycles later
    addVec(1, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h0000, 16'h0000);
    addVec(0, 2'b11, 2'b00, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 2'b00, 1, 0, 16'h0001, 16'h0000, 16'h0000);
    addVec(0, 2'b11, 2'b00, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 2'b00, 1, 0, 16'h0001, 16'h0000, 16'h0000);
    addVec(0, 2'b11, 2'b00, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 2'b01, 0, 0, 16'h0001, 16'h0000, 16'h00AA);
    addVec(0, 2'b10, 2'b00, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 2'b00, 1, 0, 16'h0002, 16'h0000, 16'h00AA);
    addVec(0, 2'b10, 2'b00, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 2'b00, 1, 0, 16'h0002, 16'h0000, 16'h00AA);
    addVec(0, 2'b10, 2'b00, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 2'b10, 0, 0, 16'h0002, 16'h0000, 16'h00BB);
    addVec(0, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0002, 16'h0000, 16'h00BB);
    // Both cores request continuously: grants alternate 0,1,0,1
    addVec(0, 2'b11, 2'b00, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 2'b00, 1, 0, 16'h0001, 16'h0000, 16'h00BB);
    addVec(0, 2'b11, 2'b00, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 2'b00, 1, 0, 16'h0001, 16'h0000, 16'h00BB);
    addVec(0, 2'b11, 2'b00, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 2'b01, 0, 0, 16'h0001, 16'h0000, 16'h00AA);
    addVec(0, 2'b11, 2'b00, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 2'b00, 1, 0, 16'h0002, 16'h0000, 16'h00AA);
    addVec(0, 2'b11, 2'b00, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 2'b00, 1, 0, 16'h0002, 16'h0000, 16'h00AA);
    addVec(0, 2'b11, 2'b00, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 2'b10, 0, 0, 16'h0002, 16'h0000, 16'h00BB);
    addVec(0, 2'b11, 2'b00, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 2'b00, 1, 0, 16'h0001, 16'h0000, 16'h00BB);
    addVec(0, 2'b11, 2'b00, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 2'b00, 1, 0, 16'h0001, 16'h0000, 16'h00BB);
    addVec(0, 2'b11, 2'b00, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 2'b01, 0, 0, 16'h0001, 16'h0000, 16'h00AA);
    addVec(0, 2'b11, 2'b00, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 2'b00, 1, 0, 16'h0002, 16'h0000, 16'h00AA);
    addVec(0, 2'b11, 2'b00, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 2'b00, 1, 0, 16'h0002, 16'h0000, 16'h00AA);
    addVec(0, 2'b11, 2'b00, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 2'b10, 0, 0, 16'h0002, 16'h0000, 16'h00BB);
    addVec(0, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0002, 16'h0000, 16'h00BB);
    // Core1 alone, holds req through its ack cycle: no re-grant, busy stays low
    addVec(0, 2'b10, 2'b00, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 2'b00, 1, 0, 16'h0001, 16'h0000, 16'h00BB);
    addVec(0, 2'b10, 2'b00, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 2'b00, 1, 0, 16'h0001, 16'h0000, 16'h00BB);
    addVec(0, 2'b10, 2'b00, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 2'b10, 0, 0, 16'h0001, 16'h0000, 16'h00AA);
    addVec(0, 2'b10, 2'b00, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0001, 16'h0000, 16'h00AA);
    addVec(0, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0001, 16'h0000, 16'h00AA);
    // Read 0x3, then write 0x4=0xBEEF (rdata keeps 0x1234), then read 0x4 back via core1
    addVec(0, 2'b01, 2'b00, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1, 0, 16'h0003, 16'h0000, 16'h00AA);
    addVec(0, 2'b01, 2'b00, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1, 0, 16'h0003, 16'h0000, 16'h00AA);
    addVec(0, 2'b01, 2'b00, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 2'b01, 0, 0, 16'h0003, 16'h0000, 16'h1234);
    addVec(0, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0003, 16'h0000, 16'h1234);
    addVec(0, 2'b01, 2'b01, 16'h0004, 16'h0000, 16'hBEEF, 16'h0000, 2'b00, 1, 1, 16'h0004, 16'hBEEF, 16'h1234);
    addVec(0, 2'b01, 2'b01, 16'h0004, 16'h0000, 16'hBEEF, 16'h0000, 2'b00, 1, 0, 16'h0004, 16'hBEEF, 16'h1234);
    addVec(0, 2'b01, 2'b01, 16'h0004, 16'h0000, 16'hBEEF, 16'h0000, 2'b01, 0, 0, 16'h0004, 16'hBEEF, 16'h1234);
    addVec(0, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0004, 16'hBEEF, 16'h1234);
    addVec(0, 2'b10, 2'b00, 16'h0000, 16'h0004, 16'h0000, 16'h0000, 2'b00, 1, 0, 16'h0004, 16'h0000, 16'h1234);
    addVec(0, 2'b10, 2'b00, 16'h0000, 16'h0004, 16'h0000, 16'h0000, 2'b00, 1, 0, 16'h0004, 16'h0000, 16'h1234);
    addVec(0, 2'b10, 2'b00, 16'h0000, 16'h0004, 16'h0000, 16'h0000, 2'b10, 0, 0, 16'h0004, 16'h0000, 16'hBEEF);
    addVec(0, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0004, 16'h0000, 16'hBEEF);

    // Power-on reset
    rst   = 1'b1;
    req   = 2'b00;
    we    = 2'b00;
    addr  = 32'h0;
    wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ack",      0, {14'd0, ack},    16'h0000);
    checkOutput("reset_busy",     0, {15'd0, busy},   16'h0000);
    checkOutput("reset_mem_we",   0, {15'd0, mem_we}, 16'h0000);
    checkOutput("reset_mem_addr", 0, mem_addr,        16'h0000);
    checkOutput("reset_rdata",    0, rdata,           16'h0000);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] running %0d table steps", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkVector(i, vecs[i]);
    end

    // Async reset while idle: outputs clear with no clock edge
    @(negedge clk);
    req = 2'b00;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_ack",       100, {14'd0, ack},    16'h0000);
    checkOutput("async_rst_rdata",     100, rdata,           16'h0000);
    checkOutput("async_rst_busy",      100, {15'd0, busy},   16'h0000);
    checkOutput("async_rst_mem_we",    100, {15'd0, mem_we}, 16'h0000);
    checkOutput("async_rst_mem_addr",  100, mem_addr,        16'h0000);
    checkOutput("async_rst_mem_wdata", 100, mem_wdata,       16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Reset during ACCESS of a write aborts it: DRAM untouched, no ack
    @(negedge clk);
    req   = 2'b01;
    we    = 2'b01;
    addr  = {16'h0000, 16'h0005};
    wdata = {16'h0000, 16'h7777};
    @(posedge clk);
    #1;
    checkOutput("abort_access_mem_we",   200, {15'd0, mem_we}, 16'h0001);
    checkOutput("abort_access_mem_addr", 200, mem_addr,        16'h0005);
    checkOutput("abort_access_busy",     200, {15'd0, busy},   16'h0001);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_mem_we_fall", 201, {15'd0, mem_we}, 16'h0000);
    checkOutput("abort_busy_fall",   201, {15'd0, busy},   16'h0000);
    req = 2'b00;
    we  = 2'b00;
    @(posedge clk);
    #1;
    checkOutput("abort_dram5_kept", 202, dram[5], 16'h5A5A);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checkOutput("abort_no_ack",  203 + i, {14'd0, ack},  16'h0000);
      checkOutput("abort_no_busy", 203 + i, {15'd0, busy}, 16'h0000);
    end
    checkOutput("abort_dram5_final", 210, dram[5], 16'h5A5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
